// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package truth_table_sweeper_pkg;

  localparam int SETTLE_W = 4;
  localparam int N_IN_DEFAULT = 4;
  localparam int NUM_VEC_DEFAULT = 1 << N_IN_DEFAULT;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int numVec(input int nIn);
    return 1 << nIn;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that times how long each input vector is held before sampling.
module truth_table_sweeper_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the enabled cycle whose decrement brings the count to zero.
  assign zero_o = (count_q == W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input code into a combinational block, captures its truth table
// and scores it against a golden table latched at start.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [(1<<N_IN)-1:0]   expected_i,
  output logic [N_IN-1:0]        dut_in_o,
  input  logic                   dut_out_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [(1<<N_IN)-1:0]   table_out_o,
  output logic [N_IN:0]          mismatch_cnt_o,
  output logic                   pass_o
);

  localparam int NUM_VEC = numVec(N_IN);
  localparam logic [N_IN-1:0] LAST_CODE = '1;

  state_t               state_q, state_d;
  logic [N_IN-1:0]      index_q, index_d;
  logic [NUM_VEC-1:0]   golden_q, golden_d;
  logic [NUM_VEC-1:0]   capTable_q, capTable_d;
  logic [N_IN:0]        mismatchCnt_q, mismatchCnt_d;
  logic                 pass_q, pass_d;
  logic                 timerLoad, timerEn, timerZero;

  assign timerLoad = ((state_q == ST_IDLE) && start_i) ||
                     ((state_q == ST_SAMPLE) && (index_q != LAST_CODE));
  assign timerEn   = (state_q == ST_SETTLE);

  truth_table_sweeper_settle_timer #(
    .W(SETTLE_W)
  ) u_settle_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timerLoad),
    .loadVal_i(SETTLE_W'(SETTLE_CYCLES)),
    .en_i     (timerEn),
    .zero_o   (timerZero)
  );

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    golden_d      = golden_q;
    capTable_d    = capTable_q;
    mismatchCnt_d = mismatchCnt_q;
    pass_d        = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          golden_d      = expected_i;
          index_d       = '0;
          capTable_d    = '0;
          mismatchCnt_d = '0;
          pass_d        = 1'b0;
          state_d       = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timerZero) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        capTable_d[index_q] = dut_out_i;
        if (dut_out_i != golden_q[index_q]) begin
          mismatchCnt_d = mismatchCnt_q + (N_IN+1)'(1);
        end
        // The last code stays on dut_in through DONE and IDLE rather than wrapping.
        if (index_q == LAST_CODE) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + N_IN'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_d  = (mismatchCnt_q == '0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      golden_q      <= '0;
      capTable_q    <= '0;
      mismatchCnt_q <= '0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      golden_q      <= golden_d;
      capTable_q    <= capTable_d;
      mismatchCnt_q <= mismatchCnt_d;
      pass_q        <= pass_d;
    end
  end

  assign dut_in_o       = index_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign table_out_o    = capTable_q;
  assign mismatch_cnt_o = mismatchCnt_q;
  assign pass_o         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them on each done pulse.
module tb_truth_table_sweeper;

  localparam int N_IN    = 4;
  localparam int NUM_VEC = 16;
  localparam int SETTLE  = 1;
  localparam int SETTLE2 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] expectedIn = '0;
  logic [15:0] dutLut = '0;
  logic [3:0]  dutIn;
  logic        dutOut;
  logic        busy, done, pass;
  logic [15:0] tableOut;
  logic [4:0]  mismatchCnt;

  logic        start2 = 1'b0;
  logic [3:0]  dutIn2;
  logic        dutOut2;
  logic        busy2, done2, pass2;
  logic [15:0] tableOut2;
  logic [4:0]  mismatchCnt2;

  int testsRun = 0;
  int failCount = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  mm;
    logic        pass;
    int          acceptCycle;
  } scoreEntryT;

  scoreEntryT sb[$];
  int   holdCount[16];
  logic passPending = 1'b0;
  logic passExp = 1'b0;

  // Combinational blocks under test: a lookup table, and a 4-input XOR for the second sweeper.
  assign dutOut  = dutLut[dutIn];
  assign dutOut2 = ^dutIn2;

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expected_i(expectedIn),
    .dut_in_o(dutIn), .dut_out_i(dutOut), .busy_o(busy), .done_o(done),
    .table_out_o(tableOut), .mismatch_cnt_o(mismatchCnt), .pass_o(pass)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .expected_i(16'h6996),
    .dut_in_o(dutIn2), .dut_out_i(dutOut2), .busy_o(busy2), .done_o(done2),
    .table_out_o(tableOut2), .mismatch_cnt_o(mismatchCnt2), .pass_o(pass2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    testsRun++;
    if (actual !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, want);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    failCount++;
    $display("[TB] FAIL %s: timed out, got none, expected event", name);
  endtask

  // Reference model: apply the function to every code and score against the golden table.
  function automatic scoreEntryT buildExpect(input logic [15:0] lut, input logic [15:0] golden, input int acc);
    scoreEntryT e;
    int misses = 0;
    e.tbl = '0;
    for (int c = 0; c < NUM_VEC; c++) begin
      e.tbl[c] = lut[c];
      if (lut[c] != golden[c]) misses++;
    end
    e.mm = 5'(misses);
    e.pass = (misses == 0);
    e.acceptCycle = acc;
    return e;
  endfunction

  task automatic applyStimulus(input logic [15:0] lut, input logic [15:0] golden);
    dutLut     = lut;
    expectedIn = golden;
    start      = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(buildExpect(lut, golden, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0 && !passPending) seen = 1;
    end
    if (!seen) begin
      reportTimeout("sweep completion");
      sb.delete();
    end
  endtask

  task automatic waitCode(input logic [3:0] code);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy && dutIn == code) seen = 1;
    end
    if (!seen) reportTimeout("wait for code");
  endtask

  // Monitor: pops one expectation per done pulse; pass settles on the edge that leaves DONE.
  always @(negedge clk) begin
    scoreEntryT e;
    bit holdOk;
    if (passPending) begin
      passPending = 1'b0;
      checkOutput("pass", 32'(pass), 32'(passExp));
      checkOutput("done pulse width", 32'(done), 32'd0);
    end
    if (busy) holdCount[dutIn]++;
    if (done) begin
      if (sb.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected done: got done=1, expected no sweep pending");
      end else begin
        e = sb.pop_front();
        checkOutput("table_out", 32'(tableOut), 32'(e.tbl));
        checkOutput("mismatch_cnt", 32'(mismatchCnt), 32'(e.mm));
        checkOutput("done latency", 32'(cyc - e.acceptCycle + 1), 32'(1 + NUM_VEC * (SETTLE + 1)));
        checkOutput("dut_in last code", 32'(dutIn), 32'(NUM_VEC - 1));
        holdOk = 1;
        for (int c = 0; c < NUM_VEC; c++) begin
          if (holdCount[c] != ((c == NUM_VEC - 1) ? SETTLE + 2 : SETTLE + 1)) holdOk = 0;
        end
        checkOutput("code hold cycles", 32'(holdOk), 32'd1);
        passExp = e.pass;
        passPending = 1'b1;
      end
      for (int c = 0; c < NUM_VEC; c++) holdCount[c] = 0;
    end
  end

  task automatic checkBackToBack();
    int accept2;
    int firstDone = -1;
    int secondDone = -1;
    int lowRun = 0;
    bit idle = 0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    accept2 = cyc;
    for (int i = 0; i < 400 && secondDone < 0; i++) begin
      @(negedge clk);
      if (done2) begin
        if (firstDone < 0) firstDone = cyc;
        else secondDone = cyc;
      end
      if (firstDone >= 0 && secondDone < 0 && !busy2) lowRun++;
    end
    start2 = 1'b0;
    checkOutput("b2b first latency", 32'(firstDone - accept2 + 1), 32'(1 + NUM_VEC * (SETTLE2 + 1)));
    // DONE clock, one IDLE clock, then a full sweep of NUM_VEC*(SETTLE2+1) clocks.
    checkOutput("b2b done period", 32'(secondDone - firstDone), 32'(2 + NUM_VEC * (SETTLE2 + 1)));
    checkOutput("b2b busy low cycles", 32'(lowRun), 32'd1);
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (!busy2) idle = 1;
    end
    if (!idle) reportTimeout("b2b idle");
    checkOutput("b2b table_out", 32'(tableOut2), 32'h6996);
    checkOutput("b2b mismatch_cnt", 32'(mismatchCnt2), 32'd0);
    checkOutput("b2b pass", 32'(pass2), 32'd1);
  endtask

  initial begin
    logic [15:0] lut;
    logic [15:0] errMask;
    for (int c = 0; c < NUM_VEC; c++) holdCount[c] = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset dut_in", 32'(dutIn), 32'd0);
    checkOutput("reset table_out", 32'(tableOut), 32'd0);
    checkOutput("reset mismatch_cnt", 32'(mismatchCnt), 32'd0);
    checkOutput("reset pass", 32'(pass), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] XOR against matching golden table");
    applyStimulus(16'h6996, 16'h6996);
    waitIdle();
    $display("[TB] XOR against golden table with one wrong bit");
    applyStimulus(16'h6996, 16'h6997);
    waitIdle();
    $display("[TB] stuck-at-0 against all-ones golden table");
    applyStimulus(16'h0000, 16'hFFFF);
    waitIdle();

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(16'h6996, 16'h6996);
    waitCode(4'd7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset dut_in", 32'(dutIn), 32'd0);
    checkOutput("mid reset table_out", 32'(tableOut), 32'd0);
    checkOutput("mid reset mismatch_cnt", 32'(mismatchCnt), 32'd0);
    checkOutput("mid reset pass", 32'(pass), 32'd0);
    sb.delete();
    for (int c = 0; c < NUM_VEC; c++) holdCount[c] = 0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h6996, 16'h6996);
    waitIdle();

    $display("[TB] start and golden change while busy");
    lut = 16'($urandom);
    applyStimulus(lut, lut);
    waitCode(4'd3);
    start = 1'b1;
    expectedIn = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] random function tables");
    for (int i = 0; i < 6; i++) begin
      lut = 16'($urandom);
      errMask = (i % 2 == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
      applyStimulus(lut, lut ^ errMask);
      waitIdle();
    end

    $display("[TB] back-to-back sweeps with longer settle time");
    checkBackToBack();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
